// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    // Master indices; also the encoding of the "last granted" pointer.
    localparam logic MST_CPU = 1'b0;
    localparam logic MST_DBG = 1'b1;

    // ARB: per-cycle round robin.
    // LOCK: m1 has exclusive ownership.
    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // Tag carried alongside an outstanding read so its data can be steered back.
    typedef struct packed {
        logic valid;
        logic owner;
    } rd_tag_t;

endpackage

// File: rtl/dmem_arbiter_rd_tag_pipe.sv
// Fixed-depth shift register of read tags.
// It matches the memory read latency.
// Reset clears every stage at once, so in-flight reads are forgotten.
module rd_tag_pipe
    import dmem_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    input  logic in_owner,
    output logic out_valid,
    output logic out_owner
);

    rd_tag_t chain [DEPTH+1];
    rd_tag_t tag_out;

    assign chain[0] = '{valid: in_valid, owner: in_owner};

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            rd_tag_t tag_q;
            rd_tag_t tag_d;

            // Each stage takes the tag from the stage in front of it.
            always_comb begin
                tag_d = chain[gi];
            end

            // Stage register; the asynchronous clear drops any outstanding read.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    tag_q <= '0;
                end else begin
                    tag_q <= tag_d;
                end
            end

            assign chain[gi+1] = tag_q;
        end
    endgenerate

    assign tag_out   = chain[DEPTH];
    assign out_valid = tag_out.valid;
    assign out_owner = tag_out.owner;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one synchronous data-memory port between the CPU (m0) and the debug
// loader (m1).
// Arbitration is round robin each cycle, and m1 can lock the port for bursts.
// Read data is steered back to whichever master issued the read.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic [AW-1:0]     m0_addr,
    input  logic [DW-1:0]     m0_wdata,
    input  logic [DW/8-1:0]   m0_we,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DW-1:0]     m0_rdata,

    input  logic              m1_req,
    input  logic [AW-1:0]     m1_addr,
    input  logic [DW-1:0]     m1_wdata,
    input  logic [DW/8-1:0]   m1_we,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DW-1:0]     m1_rdata,

    output logic              mem_en,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    output logic [DW/8-1:0]   mem_we,
    input  logic [DW-1:0]     mem_rdata
);

    arb_state_t state_q;
    arb_state_t state_d;
    logic       last_q;
    logic       last_d;

    logic       tag_in_valid;
    logic       tag_out_valid;
    logic       tag_out_owner;

    // State and last-granted pointer. Reset sets last to m1 so m0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB;
            last_q  <= MST_DBG;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Grant decision and next state. Grants are combinational, so an access issues in its request cycle.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        m0_gnt  = 1'b0;
        m1_gnt  = 1'b0;
        // Nothing is granted while reset is high.
        // This keeps the memory quiet during reset.
        if (!reset) begin
            case (state_q)
                ARB: begin
                    if (m0_req && m1_req) begin
                        if (last_q == MST_CPU) begin
                            m1_gnt = 1'b1;
                        end else begin
                            m0_gnt = 1'b1;
                        end
                    end else if (m0_req) begin
                        m0_gnt = 1'b1;
                    end else if (m1_req) begin
                        m1_gnt = 1'b1;
                    end
                    // Only an actual locked grant enters LOCK.
                    // A lock without a request does nothing.
                    if (m1_gnt && m1_lock) begin
                        state_d = LOCK;
                    end
                end
                LOCK: begin
                    m1_gnt = m1_req;
                end
                default: begin
                    state_d = ARB;
                end
            endcase

            if (m0_gnt) begin
                last_d = MST_CPU;
            end
            if (m1_gnt) begin
                last_d = MST_DBG;
            end

            // The lock release takes effect one cycle later.
            // Afterwards m0 gets the next tie.
            if (state_q == LOCK && !m1_lock) begin
                state_d = ARB;
                last_d  = MST_DBG;
            end
        end
    end

    // Request mux. When idle the bus is all zero, so the memory never sees stale enables.
    always_comb begin
        mem_en    = m0_gnt | m1_gnt;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = '0;
        if (m0_gnt) begin
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            mem_we    = m0_we;
        end else if (m1_gnt) begin
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_we    = m1_we;
        end
    end

    // Tag each issued read with its owner.
    // Writes and idle cycles push an empty tag, which keeps returns one per cycle in order.
    assign tag_in_valid = mem_en && (mem_we == '0);

    rd_tag_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_rd_tag_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (tag_in_valid),
        .in_owner  (m1_gnt),
        .out_valid (tag_out_valid),
        .out_owner (tag_out_owner)
    );

    // Steer returning read data to its owner only.
    // Everyone else sees zero.
    always_comb begin
        m0_rvalid = tag_out_valid && (tag_out_owner == MST_CPU);
        m1_rvalid = tag_out_valid && (tag_out_owner == MST_DBG);
        m0_rdata  = '0;
        m1_rdata  = '0;
        if (m0_rvalid) begin
            m0_rdata = mem_rdata;
        end
        if (m1_rvalid) begin
            m1_rdata = mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with RD_LATENCY=2 and a small behavioural memory.
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int L  = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          m0_req = 1'b0, m1_req = 1'b0, m1_lock = 1'b0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic [3:0]    m0_we = '0, m1_we = '0;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_we;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] rpipe0 = '0, rpipe1 = '0;

    int total = 0;
    int bad   = 0;

    dmem_arbiter #(.AW(AW), .DW(DW), .RD_LATENCY(L)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_we     (m0_we),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_we     (m1_we),
        .m1_lock   (m1_lock),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'h5EED_0000;
    endfunction

    // Memory model: read data appears two cycles after the read strobe.
    always @(posedge clk) begin
        rpipe0 <= (mem_en && mem_we == 4'h0) ? data_of(mem_addr) : 32'h0;
        rpipe1 <= rpipe0;
    end
    assign mem_rdata = rpipe1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
        $display("t=%0t rst=%b req=%b%b lock=%b gnt=%b%b en=%b we=%h addr=%h rv=%b%b rd0=%h rd1=%h",
                 $time, reset, m0_req, m1_req, m1_lock, m0_gnt, m1_gnt, mem_en, mem_we, mem_addr,
                 m0_rvalid, m1_rvalid, m0_rdata, m1_rdata);
    endtask

    task automatic clr();
        m0_req = 0; m1_req = 0; m1_lock = 0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0; m0_we = '0; m1_we = '0;
    endtask

    initial begin
        int  j;
        logic e0, e1, v0, v1;
        logic [31:0] ed0, ed1;

        // Reset state: requests present, but nothing may issue while reset is high.
        m0_req = 1; m1_req = 1;
        settle();
        chk("rst_m0_gnt", m0_gnt, 0);
        chk("rst_m1_gnt", m1_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
        chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
        next();
        settle();
        chk("rst2_mem_en", mem_en, 0);

        // Both masters read every cycle from reset: m0 goes first, then they alternate.
        for (int k = 0; k < 7; k++) begin
            next();
            reset = 0;
            clr();
            if (k < 4) begin
                m0_req = 1; m0_addr = 32'h40;
                m1_req = 1; m1_addr = 32'h80;
            end
            settle();
            e0 = (k < 4) && (k % 2 == 0);
            e1 = (k < 4) && (k % 2 == 1);
            chk("rr_m0_gnt", m0_gnt, e0);
            chk("rr_m1_gnt", m1_gnt, e1);
            chk("rr_addr", mem_addr, e0 ? 32'h40 : (e1 ? 32'h80 : 32'h0));
            j = k - L;
            v0 = (j >= 0) && (j < 4) && (j % 2 == 0);
            v1 = (j >= 0) && (j < 4) && (j % 2 == 1);
            ed0 = v0 ? data_of(32'h40) : 32'h0;
            ed1 = v1 ? data_of(32'h80) : 32'h0;
            chk("rr_m0_rvalid", m0_rvalid, v0);
            chk("rr_m1_rvalid", m1_rvalid, v1);
            chk("rr_m0_rdata", m0_rdata, ed0);
            chk("rr_m1_rdata", m1_rdata, ed1);
        end

        // Idle cycle: the bus is zero.
        // Then a tie still goes to m0, because last was left at m1.
        next(); clr(); settle();
        chk("idle_en", mem_en, 0);
        chk("idle_we", mem_we, 0);
        chk("idle_addr", mem_addr, 0);
        chk("idle_gnt", {m0_gnt, m1_gnt}, 0);
        next(); clr();
        m0_req = 1; m0_addr = 32'h10; m0_we = 4'hF; m0_wdata = 32'h1234_5678;
        m1_req = 1; m1_addr = 32'h20;
        settle();
        chk("tie_m0_gnt", m0_gnt, 1);
        chk("tie_m1_gnt", m1_gnt, 0);
        chk("tie_we", mem_we, 4'hF);
        chk("tie_wdata", mem_wdata, 32'h1234_5678);

        // m0 alone reads 0x100 three times.
        // Each read returns L cycles later, and only to m0.
        for (int k = 0; k < 6; k++) begin
            next(); clr();
            if (k < 3) begin
                m0_req = 1; m0_addr = 32'h100;
            end
            settle();
            chk("solo_m0_gnt", m0_gnt, k < 3);
            chk("solo_addr", mem_addr, (k < 3) ? 32'h100 : 32'h0);
            v0 = (k >= L) && (k < L + 3);
            chk("solo_m0_rvalid", m0_rvalid, v0);
            chk("solo_m0_rdata", m0_rdata, v0 ? data_of(32'h100) : 32'h0);
            chk("solo_m1_rvalid", m1_rvalid, 0);
        end

        // m1 lock burst with m0 waiting.
        // m0 is locked out until the cycle after the lock falls.
        for (int k = 0; k < 9; k++) begin
            next(); clr();
            if (k < 5) begin
                m1_req = 1; m1_lock = 1; m1_addr = 32'h200;
            end
            if (k < 7) begin
                m0_req = 1; m0_addr = 32'h300;
            end
            settle();
            chk("lock_m0_gnt", m0_gnt, k == 6);
            chk("lock_m1_gnt", m1_gnt, k < 5);
            v1 = (k >= L) && (k < L + 5);
            chk("lock_m1_rvalid", m1_rvalid, v1);
            chk("lock_m1_rdata", m1_rdata, v1 ? data_of(32'h200) : 32'h0);
            chk("lock_m0_rvalid", m0_rvalid, k == 6 + L);
            chk("lock_m0_rdata", m0_rdata, (k == 6 + L) ? data_of(32'h300) : 32'h0);
        end

        // A lock without a request has no effect in ARB.
        for (int k = 0; k < 2; k++) begin
            next(); clr();
            m1_lock = 1; m0_req = 1; m0_addr = 32'h500; m0_we = 4'hF;
            settle();
            chk("nolock_m0_gnt", m0_gnt, 1);
        end

        // m1 partial write: the byte enables pass through and no read data ever comes back.
        next(); clr();
        m1_req = 1; m1_we = 4'b0011; m1_addr = 32'h8; m1_wdata = 32'hAAAA_5555;
        settle();
        chk("wr_m1_gnt", m1_gnt, 1);
        chk("wr_we", mem_we, 4'b0011);
        chk("wr_addr", mem_addr, 32'h8);
        chk("wr_wdata", mem_wdata, 32'hAAAA_5555);
        for (int k = 0; k < 3; k++) begin
            next(); clr(); settle();
            chk("wr_no_rvalid", {m0_rvalid, m1_rvalid}, 0);
        end

        // Reset arrives one cycle after an m0 read.
        // The outputs drop immediately and the read never returns.
        next(); clr();
        m0_req = 1; m0_addr = 32'h400;
        settle();
        chk("rr5_m0_gnt", m0_gnt, 1);
        next(); clr();
        reset = 1; m0_req = 1; m1_req = 1; m0_addr = 32'h404; m0_we = 4'h1;
        settle();
        chk("mid_rst_gnt", {m0_gnt, m1_gnt}, 0);
        chk("mid_rst_en", mem_en, 0);
        chk("mid_rst_we", mem_we, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_rvalid", m0_rvalid, 0);
        next(); clr(); reset = 0;
        settle();
        chk("drop_m0_rvalid", m0_rvalid, 0);
        chk("drop_m0_rdata", m0_rdata, 0);
        next(); clr(); settle();
        chk("drop2_m0_rvalid", m0_rvalid, 0);
        next(); clr();
        m0_req = 1; m1_req = 1;
        settle();
        chk("post_rst_tie", {m0_gnt, m1_gnt}, 2'b10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
